iter_shifter: RTL and testbench
===============================

ITER_SHIFTER -- requirements
Module: iter_shifter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (>= 8, power of 2).
REQ-002 Parameter STEP, default 4, maximum bits shifted per enabled cycle (1 <= STEP <= WIDTH, power of 2).
REQ-003 Derived constant AW = clog2(WIDTH)+1, width of the shift-amount port.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  enable; en=0 freezes shift progress and state (stall).
REQ-007 start  input  1  request; accepted on a rising edge where start=1 and ready=1.
REQ-008 dir  input  1  0 = left, 1 = right; captured at accept.
REQ-009 mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved; captured at accept.
REQ-010 amt  input  AW  shift amount, unsigned; captured at accept.
REQ-011 in  input  WIDTH  operand; captured at accept.
REQ-012 ready  output  1  high only in IDLE.
REQ-013 busy  output  1  high in SHIFT and DONE.
REQ-014 done  output  1  one-cycle pulse, high exactly in DONE.
REQ-015 q  output  WIDTH  registered result; updates only on the edge entering DONE, held otherwise.

Function
REQ-016 FSM states IDLE, SHIFT, DONE; transitions occur only on edges where en=1 (except reset).
REQ-017 Accept (IDLE, start=1, en=1): load working register with in, latch dir/mode, load remaining = effective amount.
REQ-018 Effective amount: logical/arithmetic = min(amt, WIDTH); rotate = amt mod WIDTH.
REQ-019 Accept with effective amount 0: go directly to DONE, q = in.
REQ-020 SHIFT: each enabled edge shifts by k = min(STEP, remaining), remaining -= k; edge where remaining reaches 0 enters DONE and loads q.
REQ-021 Latency: done high in the cycle after edge N = ceil(eff/STEP) enabled edges after accept (minimum 1 cycle for eff=0).
REQ-022 Logical: zero fill both directions; eff=WIDTH gives all-zero result.
REQ-023 Arithmetic: right fills with latched sign bit (eff=WIDTH gives all sign bits); left identical to logical.
REQ-024 Rotate: bits shifted out re-enter at opposite end; result independent of STEP.
REQ-025 Mode 11 behaves exactly as logical.
REQ-026 DONE -> IDLE on next enabled edge; start asserted during SHIFT or DONE is ignored, not queued.
REQ-027 Changes to in/amt/dir/mode while busy have no effect on the operation in progress.
REQ-028 en=0 in DONE holds done high until an enabled edge.

Reset
REQ-029 clr=0 asynchronously forces state IDLE, q=0, done=0, busy=0, ready=1, remaining=0, working register=0.
REQ-030 Reset mid-operation abandons the operation; no done pulse is produced for it.
REQ-031 After clr deasserts, the first enabled edge with start=1 is accepted normally.

Structure
REQ-032 Package shifter_pkg holds the mode encoding enum, the FSM state enum, and the AW width function.
REQ-033 One sub-module shift_step: combinational single-step shift of a WIDTH word by k in 0..STEP for given dir/mode; instantiated once.

Verification (WIDTH=32, STEP=4)
REQ-034 in=32'h7105c1a6, dir=0, mode=00, amt=12 -> done 3 enabled cycles after accept, q=32'h5c1a6000.
REQ-035 in=32'h80000000, dir=1, mode=01, amt=31 -> 8 shift cycles, q=32'hffffffff; same with amt=40 -> q=32'hffffffff.
REQ-036 in=32'h7105c1a6, dir=1, mode=10, amt=40 -> q=32'ha67105c1 after 2 shift cycles; amt=0 -> q=32'h7105c1a6, done next cycle.
REQ-037 Op of REQ-034 with en=0 for 5 cycles mid-SHIFT -> done delayed by exactly 5 cycles, q unchanged; start pulsed while busy ignored.
REQ-038 clr=0 asserted during SHIFT -> q=0, ready=1, done never pulses for that op; new op afterwards completes per REQ-034.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared encodings and sizing helper for the iterative shifter.
// Holds the shift-mode and FSM-state enums plus the amount-port width function.
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_LOG = 2'b00,
        MODE_ARI = 2'b01,
        MODE_ROT = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // One extra bit lets the amount port express a full-width shift and beyond.
    function automatic int shift_aw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves a WIDTH word by k (0..STEP) bits
// left or right in logical, arithmetic or rotate mode (reserved mode = logical).
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int KW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] word,
    input  logic [KW-1:0]    k,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result
);

    logic [31:0] k_ext;
    logic [31:0] k_inv;

    assign k_ext = 32'(k);
    // Complementary distance; at k=0 this is WIDTH, which shifts everything out.
    assign k_inv = 32'(WIDTH) - k_ext;

    always_comb begin
        result = word;
        if (mode == MODE_ROT) begin
            if (dir) result = (word >> k_ext) | (word << k_inv);
            else     result = (word << k_ext) | (word >> k_inv);
        end else if (dir && (mode == MODE_ARI)) begin
            result = $signed(word) >>> k_ext;
        end else if (dir) begin
            result = word >> k_ext;
        end else begin
            result = word << k_ext;
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle barrel-shift replacement: shifts at most STEP bits per enabled
// cycle, then presents the registered result with a one-cycle done pulse.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int AW   = shift_aw(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       state_dbg
);

    localparam int KW = $clog2(STEP + 1);
    localparam logic [AW-1:0] WIDTH_A = AW'(WIDTH);
    localparam logic [AW-1:0] STEP_A  = AW'(STEP);

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step_out;
    logic [AW-1:0]    rem;
    logic [AW-1:0]    eff_amt;
    logic [AW-1:0]    k_a;
    logic [KW-1:0]    k;
    logic             dir_q;
    mode_t            mode_q;

    // Rotation wraps modulo WIDTH; other modes saturate at a full-width shift.
    always_comb begin
        eff_amt = amt;
        if (mode == MODE_ROT)     eff_amt = {1'b0, amt[AW-2:0]};
        else if (amt > WIDTH_A)   eff_amt = WIDTH_A;
    end

    assign k_a = (rem > STEP_A) ? STEP_A : rem;
    assign k   = k_a[KW-1:0];

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .word   (work),
        .k      (k),
        .dir    (dir_q),
        .mode   (mode_q),
        .result (step_out)
    );

    // Handshake: a request is taken on a rising edge with start && ready && en;
    // start seen in any other state is dropped, never queued.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= ST_IDLE;
            work   <= '0;
            rem    <= '0;
            dir_q  <= 1'b0;
            mode_q <= MODE_LOG;
            q      <= '0;
        end else if (en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work   <= in;
                        dir_q  <= dir;
                        mode_q <= mode_t'(mode);
                        rem    <= eff_amt;
                        if (eff_amt == '0) begin
                            q     <= in;
                            state <= ST_DONE;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    work <= step_out;
                    rem  <= rem - k_a;
                    if (rem == k_a) begin
                        q     <= step_out;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready     = (state == ST_IDLE);
    assign busy      = (state == ST_SHIFT) || (state == ST_DONE);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed self-checking bench for iter_shifter at WIDTH=32, STEP=4.
module tb_iter_shifter;

    logic        clk;
    logic        clr;
    logic        en;
    logic        start;
    logic        dir;
    logic [1:0]  mode;
    logic [5:0]  amt;
    logic [31:0] din;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic [1:0]  state_dbg;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [31:0] din;
        logic        dir;
        logic [1:0]  mode;
        logic [5:0]  amt;
        logic [31:0] exp_q;
        int          exp_cyc;
    } vec_t;

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .start     (start),
        .dir       (dir),
        .mode      (mode),
        .amt       (amt),
        .in        (din),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .q         (q),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op; cycles = enabled edges after the accept edge until done is seen.
    task automatic run_op(input logic [31:0] a_in, input logic a_dir, input logic [1:0] a_mode,
                          input logic [5:0] a_amt, output logic [31:0] r_q, output int r_cycles,
                          output bit r_timeout);
        int guard;
        r_timeout = 1'b0;
        guard = 0;
        en = 1'b1;
        while (!ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (!ready) r_timeout = 1'b1;
        din = a_in; dir = a_dir; mode = a_mode; amt = a_amt; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        din = ~a_in; dir = ~a_dir; mode = ~a_mode; amt = 6'h3f;
        r_cycles = 0;
        while (!done && r_cycles < 100) begin
            @(posedge clk); #1; r_cycles++;
        end
        if (!done) r_timeout = 1'b1;
        r_q = q;
    endtask

    task automatic test_reset();
        clr = 1'b0; en = 1'b0; start = 1'b0; dir = 1'b0; mode = 2'b00; amt = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b expected 1", ready); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done); end
        tests_run++; if (q !== 32'h0) begin tests_failed++; $display("FAIL reset_q: got %h expected 00000000", q); end
        tests_run++; if (state_dbg !== 2'b00) begin tests_failed++; $display("FAIL reset_state: got %b expected 00", state_dbg); end
        clr = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_logical();
        vec_t v[4];
        logic [31:0] r_q; int cyc; bit to;
        v[0] = '{32'h7105c1a6, 1'b0, 2'b00, 6'd12, 32'h5c1a6000, 3};
        v[1] = '{32'hf0000000, 1'b1, 2'b00, 6'd8,  32'h00f00000, 2};
        v[2] = '{32'hffffffff, 1'b0, 2'b11, 6'd32, 32'h00000000, 8};
        v[3] = '{32'hffffffff, 1'b0, 2'b00, 6'd63, 32'h00000000, 8};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].din, v[i].dir, v[i].mode, v[i].amt, r_q, cyc, to);
            tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL logical_timeout[%0d]: got %b expected 0", i, to); end
            tests_run++; if (r_q !== v[i].exp_q) begin tests_failed++; $display("FAIL logical_q[%0d]: got %h expected %h", i, r_q, v[i].exp_q); end
            tests_run++; if (cyc != v[i].exp_cyc) begin tests_failed++; $display("FAIL logical_latency[%0d]: got %0d expected %0d", i, cyc, v[i].exp_cyc); end
            @(posedge clk); #1;
            tests_run++; if (done !== 1'b0 || ready !== 1'b1) begin tests_failed++; $display("FAIL logical_done_pulse[%0d]: got done=%b ready=%b expected done=0 ready=1", i, done, ready); end
            tests_run++; if (q !== v[i].exp_q) begin tests_failed++; $display("FAIL logical_q_hold[%0d]: got %h expected %h", i, q, v[i].exp_q); end
        end
    endtask

    task automatic test_arith();
        vec_t v[4];
        logic [31:0] r_q; int cyc; bit to;
        v[0] = '{32'h80000000, 1'b1, 2'b01, 6'd31, 32'hffffffff, 8};
        v[1] = '{32'h80000000, 1'b1, 2'b01, 6'd40, 32'hffffffff, 8};
        v[2] = '{32'h7105c1a6, 1'b1, 2'b01, 6'd5,  32'h03882e0d, 2};
        v[3] = '{32'h8000000f, 1'b0, 2'b01, 6'd4,  32'h000000f0, 1};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].din, v[i].dir, v[i].mode, v[i].amt, r_q, cyc, to);
            tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL arith_timeout[%0d]: got %b expected 0", i, to); end
            tests_run++; if (r_q !== v[i].exp_q) begin tests_failed++; $display("FAIL arith_q[%0d]: got %h expected %h", i, r_q, v[i].exp_q); end
            tests_run++; if (cyc != v[i].exp_cyc) begin tests_failed++; $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, cyc, v[i].exp_cyc); end
        end
    endtask

    task automatic test_rotate();
        vec_t v[5];
        logic [31:0] r_q; int cyc; bit to;
        v[0] = '{32'h7105c1a6, 1'b1, 2'b10, 6'd40, 32'ha67105c1, 2};
        v[1] = '{32'h12345678, 1'b0, 2'b10, 6'd36, 32'h23456781, 1};
        v[2] = '{32'h12345678, 1'b0, 2'b10, 6'd32, 32'h12345678, 0};
        v[3] = '{32'h00000001, 1'b1, 2'b10, 6'd7,  32'h02000000, 2};
        v[4] = '{32'h7105c1a6, 1'b1, 2'b10, 6'd0,  32'h7105c1a6, 0};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].din, v[i].dir, v[i].mode, v[i].amt, r_q, cyc, to);
            tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL rotate_timeout[%0d]: got %b expected 0", i, to); end
            tests_run++; if (r_q !== v[i].exp_q) begin tests_failed++; $display("FAIL rotate_q[%0d]: got %h expected %h", i, r_q, v[i].exp_q); end
            tests_run++; if (cyc != v[i].exp_cyc) begin tests_failed++; $display("FAIL rotate_latency[%0d]: got %0d expected %0d", i, cyc, v[i].exp_cyc); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] r_q; int cyc; bit to;
        int edges;
        run_op(32'h12345678, 1'b0, 2'b10, 6'd4, r_q, cyc, to);
        tests_run++; if (r_q !== 32'h23456781) begin tests_failed++; $display("FAIL stall_pre_q: got %h expected 23456781", r_q); end
        @(posedge clk); #1;
        din = 32'h7105c1a6; dir = 1'b0; mode = 2'b00; amt = 6'd12; start = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        @(posedge clk); #1; edges++;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin start = 1'b1; din = 32'hdeadbeef; amt = 6'd1; end
            else start = 1'b0;
            @(posedge clk); #1; edges++;
            tests_run++; if (q !== 32'h23456781 || busy !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL stall_hold[%0d]: got q=%h busy=%b done=%b expected q=23456781 busy=1 done=0", i, q, busy, done); end
        end
        start = 1'b0; en = 1'b1;
        while (!done && edges < 60) begin @(posedge clk); #1; edges++; end
        tests_run++; if (edges != 8) begin tests_failed++; $display("FAIL stall_latency: got %0d expected 8", edges); end
        tests_run++; if (q !== 32'h5c1a6000) begin tests_failed++; $display("FAIL stall_q: got %h expected 5c1a6000", q); end
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL stall_done_hold: got %b expected 1", done); end
        en = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (ready !== 1'b1 || done !== 1'b0) begin tests_failed++; $display("FAIL stall_return_idle: got ready=%b done=%b expected ready=1 done=0", ready, done); end
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (ready !== 1'b1 || q !== 32'h5c1a6000) begin tests_failed++; $display("FAIL stall_no_queue: got ready=%b q=%h expected ready=1 q=5c1a6000", ready, q); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r_q; int cyc; bit to;
        int done_seen;
        din = 32'h80000000; dir = 1'b1; mode = 2'b01; amt = 6'd31; start = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        tests_run++; if (q !== 32'h0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("FAIL midreset_outputs: got q=%h ready=%b busy=%b done=%b expected q=0 ready=1 busy=0 done=0", q, ready, busy, done); end
        @(posedge clk); #1;
        clr = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        tests_run++; if (done_seen != 0) begin tests_failed++; $display("FAIL midreset_no_done: got %0d done cycles expected 0", done_seen); end
        run_op(32'h7105c1a6, 1'b0, 2'b00, 6'd12, r_q, cyc, to);
        tests_run++; if (to !== 1'b0) begin tests_failed++; $display("FAIL midreset_timeout: got %b expected 0", to); end
        tests_run++; if (r_q !== 32'h5c1a6000) begin tests_failed++; $display("FAIL midreset_q: got %h expected 5c1a6000", r_q); end
        tests_run++; if (cyc != 3) begin tests_failed++; $display("FAIL midreset_latency: got %0d expected 3", cyc); end
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_logical();
        test_arith();
        test_rotate();
        test_stall();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
